mem_arbiter: RTL

//   Two-master, one-slave arbiter for the shared 32-bit memory bus between the cpu core
//   and the memory. Port 0 serves the cpu core; port 1 serves a second bus master
//   (DMA/debug loader). One transaction is granted at a time, the granted master's

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles every bus signal around the two-master / one-memory arbiter:
//     s0_*, s1_*  requester ports (req, addr, wdata, wstrobe -> rdata, done, err)
//     mem_*       memory port (ready, addr, wdata, wstrobe -> rdata, done)
//   Modports:
//     slave   the arbiter's view: it serves the requesters and drives the memory
//     master  the surroundings' view: requesters plus the memory itself
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  // Port 0 (cpu core)
  logic        s0_req;
  logic [31:0] s0_addr;
  logic [31:0] s0_wdata;
  logic        s0_wstrobe;
  logic [31:0] s0_rdata;
  logic        s0_done;
  logic        s0_err;

  // Port 1 (DMA / debug loader)
  logic        s1_req;
  logic [31:0] s1_addr;
  logic [31:0] s1_wdata;
  logic        s1_wstrobe;
  logic [31:0] s1_rdata;
  logic        s1_done;
  logic        s1_err;

  // Memory side
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wstrobe;
  logic [31:0] mem_rdata;
  logic        mem_done;

  modport slave (
    input  s0_req, s0_addr, s0_wdata, s0_wstrobe,
    output s0_rdata, s0_done, s0_err,
    input  s1_req, s1_addr, s1_wdata, s1_wstrobe,
    output s1_rdata, s1_done, s1_err,
    output mem_ready, mem_addr, mem_wdata, mem_wstrobe,
    input  mem_rdata, mem_done
  );

  modport master (
    output s0_req, s0_addr, s0_wdata, s0_wstrobe,
    input  s0_rdata, s0_done, s0_err,
    output s1_req, s1_addr, s1_wdata, s1_wstrobe,
    input  s1_rdata, s1_done, s1_err,
    input  mem_ready, mem_addr, mem_wdata, mem_wstrobe,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-master, one-slave arbiter for the shared 32-bit memory bus. One
//   transaction is granted at a time; the granted master's request is muxed
//   onto the memory port and the completion is routed back to it. A watchdog
//   terminates transactions the memory never completes (done + err).
// Parameters
//   FIXED_PRIO      1: port 0 always wins contention, 0: round-robin
//   TIMEOUT_CYCLES  BUSY cycles before forced termination, 0 disables
//   TMR_W           watchdog counter width, TIMEOUT_CYCLES < 2**TMR_W
// Ports
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   mem_arbiter_if.slave: requester ports s0/s1 and the memory port
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMR_W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = WDOG_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;            // 0: port 0, 1: port 1
  logic             last_grant_q, last_grant_d;  // port of the last completed transaction
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic xact_end;   // transaction finishes this cycle
  logic xact_err;   // ... and it was ended by the watchdog
  logic done_vld;
  logic busy;

  // NOTE: every variable assigned in an always_comb gets a default on entry,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tmr_d        = tmr_q;
    xact_end     = 1'b0;
    xact_err     = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_done here is deliberately ignored.
        if (bus.s0_req || bus.s1_req) begin
          state_d = BUSY;
          tmr_d   = '0;
          if (bus.s0_req && bus.s1_req) begin
            // Round-robin favours the port that did not complete last.
            grant_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
          end else begin
            grant_d = bus.s1_req;
          end
        end
      end

      BUSY: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (bus.mem_done) begin
          xact_end     = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (WDOG_EN && (tmr_q == TMR_LAST)) begin
          xact_end     = 1'b1;
          xact_err     = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;   // port 0 wins the first contention
      tmr_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tmr_q        <= tmr_d;
    end
  end

  assign busy = (state_q == BUSY);

  // A reset landing on the completing cycle abandons the transaction, so the
  // completion must not escape to the requester.
  assign done_vld = xact_end & ~rst;

  // Memory port: the granted master's request, zero outside BUSY.
  assign bus.mem_ready   = busy;
  assign bus.mem_addr    = busy ? (grant_q ? bus.s1_addr  : bus.s0_addr)  : '0;
  assign bus.mem_wdata   = busy ? (grant_q ? bus.s1_wdata : bus.s0_wdata) : '0;
  assign bus.mem_wstrobe = busy & (grant_q ? bus.s1_wstrobe : bus.s0_wstrobe);

  // Read data is broadcast; done is what qualifies it.
  assign bus.s0_rdata = bus.mem_rdata;
  assign bus.s1_rdata = bus.mem_rdata;

  assign bus.s0_done = done_vld & ~grant_q;
  assign bus.s1_done = done_vld &  grant_q;
  assign bus.s0_err  = done_vld & xact_err & ~grant_q;
  assign bus.s1_err  = done_vld & xact_err &  grant_q;

endmodule
